// File: rtl/tt_um_counter_checker.sv
// Receive-side sequence checker for the free-running 8-bit counter tile.
// Optional input synchronizer enabled by defining COUNT_CHK_SYNC_EN.
module tt_um_counter_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    CHECK  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  logic [7:0] data_s;
  logic       valid_s;
  logic       clr_s;
  logic       sel_s;

`ifdef COUNT_CHK_SYNC_EN
  logic [10:0] sync1_q;
  logic [10:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {uio_in[2:0], ui_in};
      sync2_q <= sync1_q;
    end
  end

  assign data_s  = sync2_q[7:0];
  assign valid_s = sync2_q[8];
  assign clr_s   = sync2_q[9];
  assign sel_s   = sync2_q[10];
`else
  assign data_s  = ui_in;
  assign valid_s = uio_in[0];
  assign clr_s   = uio_in[1];
  assign sel_s   = uio_in[2];
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  state_t     state_q,      state_d;
  logic [7:0] expected_q,   expected_d;
  logic [7:0] err_cnt_q,    err_cnt_d;
  logic [3:0] good_run_q,   good_run_d;
  logic [3:0] miss_run_q,   miss_run_d;
  logic       err_pulse_q,  err_pulse_d;
  logic       err_sticky_q, err_sticky_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      expected_q   <= '0;
      err_cnt_q    <= '0;
      good_run_q   <= '0;
      miss_run_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      err_cnt_q    <= err_cnt_d;
      good_run_q   <= good_run_d;
      miss_run_q   <= miss_run_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  logic       match;
  logic [3:0] good_inc;
  logic [3:0] miss_inc;

  assign match    = (data_s == expected_q);
  assign good_inc = good_run_q + 4'd1;
  assign miss_inc = miss_run_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    err_cnt_d    = err_cnt_q;
    good_run_d   = good_run_q;
    miss_run_d   = miss_run_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;

    case (state_q)
      HUNT: begin
        if (valid_s) begin
          expected_d = data_s + 8'd1;
          good_run_d = '0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (valid_s) begin
          if (match) begin
            expected_d = expected_q + 8'd1;
            good_run_d = good_inc;
            if (good_inc == LOCK_N) begin
              state_d    = LOCKED;
              miss_run_d = '0;
            end
          end else begin
            expected_d = data_s + 8'd1;
            good_run_d = '0;
          end
        end
      end
      LOCKED: begin
        if (valid_s) begin
          if (match) begin
            expected_d = expected_q + 8'd1;
            miss_run_d = '0;
          end else begin
            err_cnt_d    = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            expected_d   = data_s + 8'd1;
            miss_run_d   = miss_inc;
            if (miss_inc == UNLOCK_N) begin
              state_d    = HUNT;
              good_run_d = '0;
            end
          end
        end
      end
      // Unused encoding falls back to HUNT regardless of valid.
      default: state_d = HUNT;
    endcase

    if (clr_s) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
      err_pulse_d  = 1'b0;
    end
  end

  logic locked;
  logic hunting;

  assign locked  = (state_q == LOCKED);
  assign hunting = (state_q == HUNT);

  assign uio_out = {hunting, err_sticky_q, err_pulse_q, locked, 4'b0000};
  assign uio_oe  = 8'hF0;
  assign uo_out  = sel_s ? expected_q : err_cnt_q;

endmodule

// File: tb/tb_tt_um_counter_checker.sv
// Directed self-checking bench for tt_um_counter_checker (default parameters).
module tb_tt_um_counter_checker;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int total;
  int bad;

  tt_um_counter_checker #(
    .LOCK_COUNT  (4),
    .UNLOCK_COUNT(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // uio_out status: bit7 hunting, bit6 sticky, bit5 pulse, bit4 locked
  task automatic chk_st(input string tag, input logic [7:0] st, input logic [7:0] uo);
    chk({tag, ".uio_out"}, uio_out, st);
    chk({tag, ".uo_out"}, uo_out, uo);
  endtask

  // One sample; returns #1 after the edge whose status reflects it.
  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic s);
    @(negedge clk);
    ui_in  = d;
    uio_in = {5'b00000, s, c, v};
    @(posedge clk);
`ifdef COUNT_CHK_SYNC_EN
    #1;
    uio_in[1:0] = 2'b00;
    @(posedge clk);
    @(posedge clk);
`endif
    #1;
  endtask

  logic [7:0] e;
  logic [7:0] m;

  initial begin
    total  = 0;
    bad    = 0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h04;
    rst_n  = 1'b0;

    #3;
    chk_st("reset_sel1", 8'h80, 8'h00);
    chk("uio_oe", uio_oe, 8'hF0);
    uio_in = 8'h00;
    #1;
`ifndef COUNT_CHK_SYNC_EN
    chk_st("reset_sel0", 8'h80, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire on 10..14
    step(1, 8'd10, 0, 0); chk_st("acq10", 8'h00, 8'h00);
    step(1, 8'd11, 0, 0); chk_st("acq11", 8'h00, 8'h00);
    step(1, 8'd12, 0, 0); chk_st("acq12", 8'h00, 8'h00);
    step(1, 8'd13, 0, 0); chk_st("acq13", 8'h00, 8'h00);
    step(1, 8'd14, 0, 1); chk_st("acq14", 8'h10, 8'd15);
    step(0, 8'd99, 0, 0); chk_st("acq_cnt", 8'h10, 8'h00);

    // Re-acquire near the top of the range and cross the wrap
    #2 rst_n = 1'b0;
    #1 chk_st("rst_mid", 8'h80, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'hFA, 0, 0);
    step(1, 8'hFB, 0, 0);
    step(1, 8'hFC, 0, 0);
    step(1, 8'hFD, 0, 0); chk_st("wrap_chk", 8'h00, 8'h00);
    step(1, 8'hFE, 0, 1); chk_st("wrap_lock", 8'h10, 8'hFF);
    step(1, 8'hFF, 0, 0); chk_st("wrap_ff", 8'h10, 8'h00);
    step(1, 8'h00, 0, 1); chk_st("wrap_00", 8'h10, 8'h01);
    step(1, 8'h01, 0, 0); chk_st("wrap_01", 8'h10, 8'h00);

    for (int unsigned i = 2; i <= 20; i++) step(1, 8'(i), 0, 0);
    chk_st("run_to_20", 8'h10, 8'h00);

    // Single injected error, then resync
    step(1, 8'd40, 0, 0); chk_st("inj40", 8'h70, 8'd1);
    step(1, 8'd41, 0, 0); chk_st("inj41", 8'h50, 8'd1);
    step(1, 8'd42, 0, 1); chk_st("inj42", 8'h50, 8'd43);

    // Three consecutive mismatches drop lock
    step(1, 8'd5, 0, 0);  chk_st("miss1", 8'h70, 8'd2);
    step(1, 8'd99, 0, 0); chk_st("miss2", 8'h70, 8'd3);
    step(1, 8'd7, 0, 0);  chk_st("miss3", 8'hE0, 8'd4);
    step(1, 8'd50, 0, 0); chk_st("relock50", 8'h40, 8'd4);
    step(1, 8'd51, 0, 0);
    step(1, 8'd52, 0, 0);
    step(1, 8'd53, 0, 0); chk_st("relock53", 8'h40, 8'd4);
    step(1, 8'd54, 0, 1); chk_st("relock54", 8'h50, 8'd55);

    // clr behaviour
    step(1, 8'd55, 1, 0);  chk_st("clr_match", 8'h10, 8'd0);
    step(1, 8'd200, 0, 0); chk_st("err_a", 8'h70, 8'd1);
    step(1, 8'd201, 0, 0); chk_st("ok_a", 8'h50, 8'd1);
    step(1, 8'd100, 0, 0); chk_st("err_b", 8'h70, 8'd2);
    step(1, 8'd7, 1, 1);   chk_st("clr_wins", 8'h10, 8'd8);
    step(1, 8'd8, 0, 0);   chk_st("after_clr", 8'h10, 8'd0);

    // Saturation: alternate mismatch/match so lock is kept
    e = 8'd9;
    for (int unsigned i = 0; i < 300; i++) begin
      m = e + 8'd100;
      step(1, m, 0, 0);
      step(1, m + 8'd1, 0, 0);
      e = m + 8'd2;
    end
    chk_st("sat_hold", 8'h50, 8'hFF);
    m = e + 8'd100;
    step(1, m, 0, 0); chk_st("sat_pulse", 8'h70, 8'hFF);
    e = m + 8'd1;

    // valid low: nothing moves except the pulse
    step(0, 8'h33, 0, 0); chk_st("idle1", 8'h50, 8'hFF);
    step(0, 8'hC4, 0, 1); chk_st("idle2", 8'h50, e);
    step(0, 8'h00, 0, 1); chk_st("idle3", 8'h50, e);
    step(0, e + 8'd7, 0, 0); chk_st("idle4", 8'h50, 8'hFF);
    step(0, 8'h5A, 0, 1); chk_st("idle5", 8'h50, e);
    step(1, e, 0, 1);     chk_st("resume", 8'h50, e + 8'd1);

    // Asynchronous reset while locked
    #2 rst_n = 1'b0;
    #1 chk_st("async_rst", 8'h80, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'd77, 0, 1); chk_st("post_rst", 8'h00, 8'd78);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
